uart_rx: RTL and testbench

UART receive controller for the 9600-baud, 8N1 serial command link from the host PC. It detects the start bit on the asynchronous line and runs the baud generator through `bps_start`. It samples each bit on the generator's mid-bit `clk_bps` strobe and delivers each received byte with a one-cycle valid pulse or a framing-error pulse. It sits between the RS-232 pin and the command decoder that loads phase/delay settings into the ultrasonic channel generators.

---
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, frames start/data/stop bits on the
// baud generator's mid-bit strobe and emits one-cycle valid or framing-error pulses.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rstn,
   input  logic                 rs232_rx,
   input  logic                 clk_bps,
   output logic                 bps_start,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_s3;
   logic                 rx_fall;
   logic [1:0]           state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;

   // Line synchroniser; s3 is a pure delay used only for edge detection
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rs232_rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign rx_fall = rx_s3 & ~rx_s2;

   // Frame FSM; a held-low line produces no new edge, so a break never restarts it
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state        <= IDLE;
         bps_start    <= 1'b0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_fall) begin
                  state     <= START;
                  bps_start <= 1'b1;
               end
            end
            START: begin
               if (clk_bps) begin
                  if (!rx_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state     <= IDLE;
                     bps_start <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (clk_bps) begin
                  shift_reg <= {rx_s2, shift_reg[DATA_BITS-1:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (clk_bps) begin
                  if (rx_s2) begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_frame_err <= 1'b1;
                  end
                  state     <= IDLE;
                  bps_start <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               bps_start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a behavioural baud generator (shortened bit time).
module tb_uart_rx;

   localparam int BIT  = 160;
   localparam int HALF = 80;

   logic       sys_clk;
   logic       sys_rstn;
   logic       rs232_rx;
   logic       clk_bps;
   logic       bps_start;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;

   int total = 0;
   int bad   = 0;

   uart_rx #(.DATA_BITS(8)) dut (
      .sys_clk      (sys_clk),
      .sys_rstn     (sys_rstn),
      .rs232_rx     (rs232_rx),
      .clk_bps      (clk_bps),
      .bps_start    (bps_start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Baud generator: strobe HALF cycles after bps_start rises, then every BIT cycles
   int bcnt = 0;
   always @(posedge sys_clk) begin
      if (!bps_start) bcnt <= 0;
      else if (bcnt == BIT - 1) bcnt <= 0;
      else bcnt <= bcnt + 1;
   end
   assign clk_bps = bps_start && (bcnt == HALF);

   // Output monitor
   int         v_cnt = 0, e_cnt = 0, wide = 0, both = 0, rises = 0, hi = 0;
   logic       prev_v = 1'b0, prev_e = 1'b0, prev_b = 1'b0;
   logic       bps_at_valid = 1'b1;
   logic [7:0] data_q[$];
   always @(negedge sys_clk) begin
      if (rx_valid) begin
         v_cnt++;
         data_q.push_back(rx_data);
         bps_at_valid = bps_start;
         if (prev_v) wide++;
      end
      if (rx_frame_err) begin
         e_cnt++;
         if (prev_e) wide++;
      end
      if (rx_valid && rx_frame_err) both++;
      if (bps_start && !prev_b) rises++;
      if (bps_start) hi++;
      prev_v = rx_valid;
      prev_e = rx_frame_err;
      prev_b = bps_start;
   end

   int b_v, b_e, b_w, b_both, b_r, b_h, b_q;

   task automatic snap();
      @(posedge sys_clk);
      b_v = v_cnt; b_e = e_cnt; b_w = wide; b_both = both;
      b_r = rises; b_h = hi; b_q = data_q.size();
      @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, output int lat);
      lat = -1;
      rs232_rx = 1'b0;
      for (int i = 1; i <= BIT; i++) begin
         @(negedge sys_clk);
         if (lat < 0 && bps_start) lat = i;
      end
      for (int b = 0; b < 8; b++) begin
         rs232_rx = d[b];
         repeat (BIT) @(negedge sys_clk);
      end
      rs232_rx = stop;
      repeat (BIT) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      sys_rstn = 1'b0;
      rs232_rx = 1'b1;
      repeat (4) @(negedge sys_clk);
      total += 4;
      if (bps_start !== 1'b0) begin bad++; $display("FAIL reset_bps got=%b exp=0", bps_start); end
      if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rx_frame_err); end
      sys_rstn = 1'b1;
      repeat (5) @(negedge sys_clk);
   endtask

   task automatic test_basic();
      int lat;
      snap();
      send_frame(8'h55, 1'b1, lat);
      repeat (5) @(negedge sys_clk);
      total += 7;
      if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      if (v_cnt - b_v !== 1) begin bad++; $display("FAIL basic_valid_cnt got=%0d exp=1", v_cnt - b_v); end
      if (rx_data !== 8'h55) begin bad++; $display("FAIL basic_data got=%h exp=55", rx_data); end
      if (e_cnt - b_e !== 0) begin bad++; $display("FAIL basic_err_cnt got=%0d exp=0", e_cnt - b_e); end
      if (wide - b_w !== 0) begin bad++; $display("FAIL basic_pulse_width got=%0d wide exp=0", wide - b_w); end
      if (bps_at_valid !== 1'b0) begin bad++; $display("FAIL basic_bps_after got=%b exp=0", bps_at_valid); end
      if (bps_start !== 1'b0) begin bad++; $display("FAIL basic_bps_idle got=%b exp=0", bps_start); end
   endtask

   task automatic test_back_to_back();
      int lat;
      snap();
      send_frame(8'hA3, 1'b1, lat);
      send_frame(8'h0F, 1'b1, lat);
      repeat (5) @(negedge sys_clk);
      total += 3;
      if (v_cnt - b_v !== 2) begin bad++; $display("FAIL b2b_valid_cnt got=%0d exp=2", v_cnt - b_v); end
      if (e_cnt - b_e !== 0) begin bad++; $display("FAIL b2b_err_cnt got=%0d exp=0", e_cnt - b_e); end
      if (data_q.size() - b_q !== 2) begin bad++; $display("FAIL b2b_data_cnt got=%0d exp=2", data_q.size() - b_q); end
      else begin
         total += 2;
         if (data_q[b_q] !== 8'hA3) begin bad++; $display("FAIL b2b_first got=%h exp=a3", data_q[b_q]); end
         if (data_q[b_q+1] !== 8'h0F) begin bad++; $display("FAIL b2b_second got=%h exp=0f", data_q[b_q+1]); end
      end
   endtask

   task automatic test_glitch();
      snap();
      rs232_rx = 1'b0;
      repeat (30) @(negedge sys_clk);
      rs232_rx = 1'b1;
      repeat (2 * BIT) @(negedge sys_clk);
      total += 5;
      if (hi - b_h !== HALF + 1) begin bad++; $display("FAIL glitch_bps_len got=%0d exp=%0d", hi - b_h, HALF + 1); end
      if (rises - b_r !== 1) begin bad++; $display("FAIL glitch_bps_rises got=%0d exp=1", rises - b_r); end
      if (v_cnt - b_v !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", v_cnt - b_v); end
      if (e_cnt - b_e !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", e_cnt - b_e); end
      if (bps_start !== 1'b0) begin bad++; $display("FAIL glitch_bps_end got=%b exp=0", bps_start); end
   endtask

   task automatic test_frame_err();
      int lat;
      snap();
      send_frame(8'h3C, 1'b1, lat);
      send_frame(8'hFF, 1'b0, lat);
      rs232_rx = 1'b1;
      repeat (BIT) @(negedge sys_clk);
      total += 4;
      if (e_cnt - b_e !== 1) begin bad++; $display("FAIL ferr_err_cnt got=%0d exp=1", e_cnt - b_e); end
      if (v_cnt - b_v !== 1) begin bad++; $display("FAIL ferr_valid_cnt got=%0d exp=1", v_cnt - b_v); end
      if (rx_data !== 8'h3C) begin bad++; $display("FAIL ferr_data_hold got=%h exp=3c", rx_data); end
      if (both !== 0) begin bad++; $display("FAIL ferr_both_high got=%0d exp=0", both); end
      snap();
      send_frame(8'h81, 1'b1, lat);
      repeat (5) @(negedge sys_clk);
      total += 3;
      if (v_cnt - b_v !== 1) begin bad++; $display("FAIL recover_valid got=%0d exp=1", v_cnt - b_v); end
      if (rx_data !== 8'h81) begin bad++; $display("FAIL recover_data got=%h exp=81", rx_data); end
      if (e_cnt - b_e !== 0) begin bad++; $display("FAIL recover_err got=%0d exp=0", e_cnt - b_e); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [7:0] d = 8'h5A;
      snap();
      rs232_rx = 1'b0;
      repeat (BIT) @(negedge sys_clk);
      for (int b = 0; b < 3; b++) begin
         rs232_rx = d[b];
         repeat (BIT) @(negedge sys_clk);
      end
      rs232_rx = d[3];
      repeat (HALF) @(negedge sys_clk);
      total += 5;
      if (bps_start !== 1'b1) begin bad++; $display("FAIL midrst_bps_before got=%b exp=1", bps_start); end
      #2 sys_rstn = 1'b0;
      #1;
      if (bps_start !== 1'b0) begin bad++; $display("FAIL midrst_bps got=%b exp=0", bps_start); end
      if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", rx_data); end
      if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", rx_valid); end
      if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", rx_frame_err); end
      rs232_rx = 1'b1;
      repeat (20) @(negedge sys_clk);
      sys_rstn = 1'b1;
      repeat (2 * BIT) @(negedge sys_clk);
      total += 3;
      if (v_cnt - b_v !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", v_cnt - b_v); end
      if (e_cnt - b_e !== 0) begin bad++; $display("FAIL midrst_no_err got=%0d exp=0", e_cnt - b_e); end
      if (rises - b_r !== 1) begin bad++; $display("FAIL midrst_rises got=%0d exp=1", rises - b_r); end
      snap();
      send_frame(8'hC6, 1'b1, lat);
      repeat (5) @(negedge sys_clk);
      total += 2;
      if (v_cnt - b_v !== 1) begin bad++; $display("FAIL postrst_valid got=%0d exp=1", v_cnt - b_v); end
      if (rx_data !== 8'hC6) begin bad++; $display("FAIL postrst_data got=%h exp=c6", rx_data); end
   endtask

   task automatic test_break();
      int lat;
      snap();
      send_frame(8'h00, 1'b0, lat);
      total += 1;
      if (e_cnt - b_e !== 1) begin bad++; $display("FAIL break_ferr got=%0d exp=1", e_cnt - b_e); end
      snap();
      repeat (20 * BIT) @(negedge sys_clk);
      total += 3;
      if (rises - b_r !== 0) begin bad++; $display("FAIL break_rises got=%0d exp=0", rises - b_r); end
      if (bps_start !== 1'b0) begin bad++; $display("FAIL break_bps got=%b exp=0", bps_start); end
      if (v_cnt - b_v + e_cnt - b_e !== 0) begin bad++; $display("FAIL break_pulses got=%0d exp=0", v_cnt - b_v + e_cnt - b_e); end
      rs232_rx = 1'b1;
      repeat (BIT) @(negedge sys_clk);
      snap();
      send_frame(8'h96, 1'b1, lat);
      repeat (5) @(negedge sys_clk);
      total += 3;
      if (rises - b_r !== 1) begin bad++; $display("FAIL after_break_rises got=%0d exp=1", rises - b_r); end
      if (v_cnt - b_v !== 1) begin bad++; $display("FAIL after_break_valid got=%0d exp=1", v_cnt - b_v); end
      if (rx_data !== 8'h96) begin bad++; $display("FAIL after_break_data got=%h exp=96", rx_data); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_break();
      total += 1;
      if (both !== 0) begin bad++; $display("FAIL never_both got=%0d exp=0", both); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
